// File: rtl/wb_mprj_region_ctrl_if.sv
// rtl/wb_mprj_region_ctrl_if.sv - Wishbone slave bus bundle for the user project region controller
interface wb_mprj_region_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_mprj_region_ctrl.sv
// rtl/wb_mprj_region_ctrl.sv - Wishbone decode to BRAM, peripheral ports or error completion
module wb_mprj_region_ctrl #(
  parameter int unsigned DELAYS      = 10,
  parameter int unsigned NUM_PERIPH  = 2,
  parameter logic [7:0]  BRAM_BASE   = 8'h38,
  parameter logic [7:0]  PERIPH_BASE = 8'h30,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_WORD    = 32'hDEADBEEF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  wb_mprj_region_ctrl_if.slave       wbs,
  output logic                       ram_en,
  output logic [3:0]                 ram_we,
  output logic [31:0]                ram_addr,
  output logic [31:0]                ram_wdata,
  input  logic [31:0]                ram_rdata,
  output logic [NUM_PERIPH-1:0]      per_req,
  output logic                       per_we,
  output logic [11:0]                per_addr,
  output logic [31:0]                per_wdata,
  output logic [3:0]                 per_sel,
  input  logic [NUM_PERIPH-1:0]      per_ready,
  input  logic [32*NUM_PERIPH-1:0]   per_rdata,
  output logic                       busy,
  output logic [15:0]                timeout_cnt
);

  localparam int IW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

  typedef enum logic [1:0] {IDLE, BRAM_WAIT, PER_WAIT, ACK} state_t;

  state_t          state_q, state_d;
  logic [31:0]     cnt_q;
  logic [31:0]     adr_q;
  logic [31:0]     wdat_q;
  logic [3:0]      sel_q;
  logic            we_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     dat_q;

  logic            req;
  logic            is_bram;
  logic            is_per;
  logic            ready_sel;
  logic            bram_last;
  logic            per_last;
  logic [31:0]     per_rd_arr [NUM_PERIPH];

  for (genvar k = 0; k < NUM_PERIPH; k++) begin : g_rd
    assign per_rd_arr[k] = per_rdata[32*k +: 32];
  end

  assign req       = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign is_bram   = (wbs.wbs_adr_i[31:24] == BRAM_BASE);
  assign is_per    = (wbs.wbs_adr_i[31:24] == PERIPH_BASE) &&
                     ({28'd0, wbs.wbs_adr_i[15:12]} < NUM_PERIPH);
  assign ready_sel = per_ready[idx_q];
  assign bram_last = (cnt_q == DELAYS - 1);
  assign per_last  = (cnt_q == TIMEOUT - 1);

  // State register; reset aborts any transfer in flight
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: decode on accept, wait for BRAM latency or peripheral ready/timeout, one-cycle ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_bram)     state_d = BRAM_WAIT;
          else if (is_per) state_d = PER_WAIT;
          else             state_d = ACK;
        end
      end
      BRAM_WAIT: begin
        if (!wbs.wbs_cyc_i)  state_d = IDLE;
        else if (bram_last)  state_d = ACK;
      end
      PER_WAIT: begin
        if (!wbs.wbs_cyc_i)           state_d = IDLE;
        else if (ready_sel || per_last) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request latch, wait counter, response capture and timeout statistics
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q       <= '0;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      dat_q       <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (req) begin
            adr_q  <= wbs.wbs_adr_i;
            wdat_q <= wbs.wbs_dat_i;
            sel_q  <= wbs.wbs_sel_i;
            we_q   <= wbs.wbs_we_i;
            idx_q  <= wbs.wbs_adr_i[12 +: IW];
            dat_q  <= wbs.wbs_we_i ? 32'd0 : ERR_WORD;
          end
        end
        BRAM_WAIT: begin
          cnt_q <= cnt_q + 32'd1;
          if (bram_last) dat_q <= ram_rdata;
        end
        PER_WAIT: begin
          cnt_q <= cnt_q + 32'd1;
          if (ready_sel) begin
            dat_q <= we_q ? 32'd0 : per_rd_arr[idx_q];
          end else if (per_last && wbs.wbs_cyc_i) begin
            dat_q <= ERR_WORD;
            if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign wbs.wbs_ack_o = (state_q == ACK);
  assign wbs.wbs_dat_o = (state_q == ACK) ? dat_q : 32'd0;

  assign ram_en    = (state_q == BRAM_WAIT);
  assign ram_we    = (ram_en && cnt_q == 32'd0) ? (sel_q & {4{we_q}}) : 4'b0;
  assign ram_addr  = ram_en ? adr_q : 32'd0;
  assign ram_wdata = ram_en ? wdat_q : 32'd0;

  assign per_req   = (state_q == PER_WAIT) ? (NUM_PERIPH'(1) << idx_q) : '0;
  assign per_we    = (state_q == PER_WAIT) & we_q;
  assign per_addr  = (state_q == PER_WAIT) ? adr_q[11:0] : 12'd0;
  assign per_wdata = (state_q == PER_WAIT) ? wdat_q : 32'd0;
  assign per_sel   = (state_q == PER_WAIT) ? sel_q : 4'd0;

endmodule

// File: tb/tb_wb_mprj_region_ctrl.sv
// tb/tb_wb_mprj_region_ctrl.sv - Directed vector bench for wb_mprj_region_ctrl
module tb_wb_mprj_region_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [1:0]  per_req;
  logic        per_we;
  logic [11:0] per_addr;
  logic [31:0] per_wdata;
  logic [3:0]  per_sel;
  logic [1:0]  per_ready = '0;
  logic [63:0] per_rdata = '0;
  logic        busy;
  logic [15:0] timeout_cnt;

  int errors = 0;
  int checks = 0;

  wb_mprj_region_ctrl_if wbs();

  wb_mprj_region_ctrl #(
    .DELAYS(10), .NUM_PERIPH(2), .BRAM_BASE(8'h38), .PERIPH_BASE(8'h30),
    .TIMEOUT(8), .ERR_WORD(32'hDEADBEEF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs.slave),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .per_req(per_req), .per_we(per_we), .per_addr(per_addr),
    .per_wdata(per_wdata), .per_sel(per_sel), .per_ready(per_ready),
    .per_rdata(per_rdata), .busy(busy), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [31:0] ram_rd;
    logic [31:0] prd;
    logic [1:0]  rdy_mask;
    int          dly;
    int          exp_lat;
    logic [31:0] exp_dat;
    logic [1:0]  exp_req;
    logic        exp_en;
    logic [15:0] exp_tcnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int          cyc_n;
    int          wait_n;
    logic        got;
    logic [1:0]  req_seen;
    logic        en_seen;
    logic        pa_set;
    logic [11:0] pa;
    logic [31:0] d;
    string       tag;
    tag = $sformatf("vec%0d", n);
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = v.we;
    wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = v.adr; wbs.wbs_dat_i = v.wdat;
    ram_rdata = v.ram_rd;
    per_rdata = v.adr[12] ? {v.prd, ~v.prd} : {~v.prd, v.prd};
    got = 1'b0; cyc_n = 0; wait_n = 0; req_seen = '0; en_seen = 1'b0;
    pa_set = 1'b0; pa = '0; d = '0;
    while (!got && cyc_n < 40) begin
      step();
      cyc_n++;
      req_seen |= per_req;
      en_seen  |= ram_en;
      if (per_req != 2'b00 && !pa_set) begin pa = per_addr; pa_set = 1'b1; end
      if (wbs.wbs_ack_o) begin
        got = 1'b1;
        d = wbs.wbs_dat_o;
      end else if (per_req != 2'b00) begin
        wait_n++;
        if (v.dly != 0 && wait_n == v.dly) per_ready = v.rdy_mask;
      end
    end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; per_ready = '0;
    check({tag, " latency"}, got ? cyc_n : -1, v.exp_lat);
    check({tag, " data"}, d, v.exp_dat);
    check({tag, " per_req"}, {30'd0, req_seen}, {30'd0, v.exp_req});
    check({tag, " ram_en"}, {31'd0, en_seen}, {31'd0, v.exp_en});
    check({tag, " timeout_cnt"}, {16'd0, timeout_cnt}, {16'd0, v.exp_tcnt});
    if (v.exp_req != 2'b00) check({tag, " per_addr"}, {20'd0, pa}, {20'd0, v.adr[11:0]});
    step();
    check({tag, " ack single"}, {31'd0, wbs.wbs_ack_o}, 32'd0);
    check({tag, " idle after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int wec;
    int lat;
    int acks;
    logic [3:0]  wev;
    logic [31:0] wd;
    logic        got;

    //          adr           we    wdat          ram_rd        prd           mask   dly lat exp_dat       req    en    tcnt
    vecs[0]  = '{32'h3800_0010, 1'b0, 32'h0,        32'h1234_5678, 32'h0,        2'b00, 0, 11, 32'h1234_5678, 2'b00, 1'b1, 16'd0};
    vecs[1]  = '{32'h3000_1020, 1'b0, 32'h0,        32'h0,         32'h0000_0055, 2'b10, 3, 4,  32'h0000_0055, 2'b10, 1'b0, 16'd0};
    vecs[2]  = '{32'h3000_0004, 1'b0, 32'h0,        32'h0,         32'hCAFE_F00D, 2'b01, 1, 2,  32'hCAFE_F00D, 2'b01, 1'b0, 16'd0};
    vecs[3]  = '{32'h3000_0008, 1'b1, 32'h1111_2222, 32'h0,        32'h7777_7777, 2'b01, 2, 3,  32'h0,         2'b01, 1'b0, 16'd0};
    vecs[4]  = '{32'h3000_1000, 1'b0, 32'h0,        32'h0,         32'h0000_0099, 2'b10, 0, 9,  32'hDEAD_BEEF, 2'b10, 1'b0, 16'd1};
    vecs[5]  = '{32'h3000_1000, 1'b0, 32'h0,        32'h0,         32'h0000_0099, 2'b01, 1, 9,  32'hDEAD_BEEF, 2'b10, 1'b0, 16'd2};
    vecs[6]  = '{32'h3000_0000, 1'b0, 32'h0,        32'h0,         32'h0BAD_F00D, 2'b01, 8, 9,  32'h0BAD_F00D, 2'b01, 1'b0, 16'd2};
    vecs[7]  = '{32'h2000_0000, 1'b0, 32'h0,        32'h5555_5555, 32'h0,        2'b11, 1, 1,  32'hDEAD_BEEF, 2'b00, 1'b0, 16'd2};
    vecs[8]  = '{32'h3000_2000, 1'b0, 32'h0,        32'h0,         32'h0,        2'b11, 1, 1,  32'hDEAD_BEEF, 2'b00, 1'b0, 16'd2};
    vecs[9]  = '{32'h2000_0000, 1'b1, 32'h1234_0000, 32'h0,        32'h0,        2'b00, 0, 1,  32'h0,         2'b00, 1'b0, 16'd2};
    vecs[10] = '{32'h38FF_FFFC, 1'b0, 32'h0,        32'hA5A5_0001, 32'h0,        2'b00, 0, 11, 32'hA5A5_0001, 2'b00, 1'b1, 16'd2};

    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = '0; wbs.wbs_adr_i = '0; wbs.wbs_dat_i = '0;
    repeat (3) step();
    check("reset ack", {31'd0, wbs.wbs_ack_o}, 32'd0);
    check("reset dat", wbs.wbs_dat_o, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset per_req", {30'd0, per_req}, 32'd0);
    check("reset ram_en", {31'd0, ram_en}, 32'd0);
    check("reset timeout_cnt", {16'd0, timeout_cnt}, 32'd0);
    rst = 1'b0;
    step();

    // stb low while idle must not start anything
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_adr_i = 32'h3800_0000;
    repeat (3) step();
    check("stb low busy", {31'd0, busy}, 32'd0);
    wbs.wbs_cyc_i = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // BRAM write: byte enables for exactly one cycle, ack after DELAYS+1
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
    wbs.wbs_sel_i = 4'b0011; wbs.wbs_adr_i = 32'h3800_0004; wbs.wbs_dat_i = 32'hAABB_CCDD;
    wec = 0; wev = '0; wd = '0; lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      step();
      lat++;
      if (ram_we != 4'b0) begin wec++; wev = ram_we; wd = ram_wdata; end
      if (wbs.wbs_ack_o) got = 1'b1;
    end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    check("bram wr we cycles", wec, 32'd1);
    check("bram wr we value", {28'd0, wev}, 32'd3);
    check("bram wr wdata", wd, 32'hAABB_CCDD);
    check("bram wr latency", got ? lat : -1, 32'd11);
    step();

    // cyc dropped mid BRAM wait: no ack, back to idle next cycle
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_adr_i = 32'h3800_0020;
    repeat (4) step();
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
    step();
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort ram_en", {31'd0, ram_en}, 32'd0);
    acks = 0;
    repeat (12) begin step(); if (wbs.wbs_ack_o) acks++; end
    check("abort no ack", acks, 32'd0);

    check("final timeout_cnt", {16'd0, timeout_cnt}, 32'd2);

    // reset mid peripheral wait: no ack, per_req dropped, counter cleared
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0; wbs.wbs_adr_i = 32'h3000_1000;
    repeat (3) step();
    check("pre-reset per_req", {30'd0, per_req}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0; wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst per_req", {30'd0, per_req}, 32'd0);
    acks = 0;
    repeat (12) begin step(); if (wbs.wbs_ack_o) acks++; end
    check("rst no ack", acks, 32'd0);
    check("rst timeout_cnt", {16'd0, timeout_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
